// File: rtl/pe_fifo_fill_arbiter.sv
// pe_fifo_fill_arbiter: round-robin sharing of one GLB read port among NUM_REQ PE FIFOs,
// with per-FIFO credits so a destination FIFO is never overrun.
module pe_fifo_fill_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic                      sram_en_o,
    output logic [ADDR_W-1:0]         sram_addr_o,
    input  logic [DATA_W-1:0]         sram_rdata_i,
    output logic [NUM_REQ-1:0]        fifo_push_o,
    output logic [DATA_W-1:0]         fifo_din_o,
    input  logic [NUM_REQ-1:0]        fifo_pop_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [IW-1:0]     rr_q, rd_id_q, hold_id_q, win;
    logic              rd_pend_q, hold_valid_q, found, push, issue, grant;
    logic [DATA_W-1:0] hold_data_q;
    logic [CW-1:0]     credit_q [NUM_REQ];
    logic [NUM_REQ-1:0] ack;

    always_comb begin
        found = 1'b0;
        win   = rr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_i[(int'(rr_q) + k) % NUM_REQ] &&
                credit_q[(int'(rr_q) + k) % NUM_REQ] != '0) begin
                found = 1'b1;
                win   = IW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    // a push that collides with a pop would be dropped by the FIFO, so it is held back
    assign push        = hold_valid_q && !fifo_pop_i[hold_id_q];
    assign issue       = rstn && !rd_pend_q && (!hold_valid_q || push);
    assign grant       = issue && found;
    assign ack         = grant ? NUM_REQ'(1) << win : '0;
    assign req_ack_o   = ack;
    assign sram_en_o   = grant;
    assign sram_addr_o = grant ? req_addr_i[int'(win)*ADDR_W +: ADDR_W] : '0;
    assign fifo_push_o = push ? NUM_REQ'(1) << hold_id_q : '0;
    assign fifo_din_o  = hold_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q         <= IW'(NUM_REQ - 1);
            rd_pend_q    <= 1'b0;
            rd_id_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_id_q    <= '0;
            hold_data_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= CW'(FIFO_DEPTH);
        end else begin
            if (grant) begin
                rr_q    <= win;
                rd_id_q <= win;
            end
            rd_pend_q <= grant;
            if (rd_pend_q) begin
                hold_data_q <= sram_rdata_i;
                hold_id_q   <= rd_id_q;
            end
            hold_valid_q <= rd_pend_q || (hold_valid_q && !push);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i] && !fifo_pop_i[i])
                    credit_q[i] <= credit_q[i] - 1'b1;
                else if (!ack[i] && fifo_pop_i[i] && credit_q[i] != CW'(FIFO_DEPTH))
                    credit_q[i] <= credit_q[i] + 1'b1;
            end
        end
    end
endmodule
